// File: rtl/regs_writeback_ctl_pkg.sv
// Shared types and sizing for the register-file writeback path.
package regs_writeback_ctl_pkg;

    localparam int REG_AW        = 5;
    localparam int WB_FIFO_DEPTH = 4;

    typedef logic [31:0] unsigned_32;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        unsigned_32        dstdata;
    } RegfileWriteType;

endpackage

// File: rtl/regs_writeback_ctl_if.sv
// Writeback request bus, register-file write port and pending-write query.
interface regs_writeback_ctl_if
    import regs_writeback_ctl_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    parameter int AW    = REG_AW
);

    logic                   wb_valid;
    logic                   wb_ready;
    logic [AW-1:0]          wb_dst;
    unsigned_32             wb_data;
    logic                   regs_hold;
    RegfileWriteType        CtlToRegs_port;
    logic                   CtlToRegs_port_sync;
    logic [AW-1:0]          rd_addr;
    logic                   rd_pending;
    logic [$clog2(DEPTH):0] wb_count;

    modport master (
        output wb_valid, wb_dst, wb_data, regs_hold, rd_addr,
        input  wb_ready, CtlToRegs_port, CtlToRegs_port_sync, rd_pending, wb_count
    );

    modport slave (
        input  wb_valid, wb_dst, wb_data, regs_hold, rd_addr,
        output wb_ready, CtlToRegs_port, CtlToRegs_port_sync, rd_pending, wb_count
    );

endinterface

// File: rtl/regs_writeback_ctl_wb_fifo.sv
// In-order writeback FIFO; exposes every slot plus its valid bit for address matching.
module wb_fifo
    import regs_writeback_ctl_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  RegfileWriteType               din_i,
    input  logic                          pop_i,
    output RegfileWriteType               head_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output RegfileWriteType [DEPTH-1:0]   entries_o,
    output logic [DEPTH-1:0]              vld_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    RegfileWriteType [DEPTH-1:0] mem_q;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q;
    logic [DEPTH-1:0]            vld_q, vld_d;

    always_comb begin
        vld_d = vld_q;
        if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
        if (push_i) vld_d[wr_ptr_q] = 1'b1;
    end

    // Pointers are DEPTH-sized so they wrap on their own; fullness comes from count_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
            vld_q   <= vld_d;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;
    assign vld_o     = vld_q;

endmodule

// File: rtl/regs_writeback_ctl.sv
// Writeback controller: x0 filter, FIFO issue to the register file, pending-write query.
// WB_FASTPATH_EN: a request arriving at an empty, unheld controller skips the FIFO.
module regs_writeback_ctl
    import regs_writeback_ctl_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    regs_writeback_ctl_if.slave  bus
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    RegfileWriteType              req, head, port_q, port_d;
    RegfileWriteType [DEPTH-1:0]  entries;
    logic [DEPTH-1:0]             ent_vld, hit;
    logic [CW-1:0]                count;
    logic                         sync_q, sync_d;
    logic                         hs, keep, fast, push, pop;

    assign req  = '{dst: bus.wb_dst, dstdata: bus.wb_data};
    assign hs   = bus.wb_valid && bus.wb_ready;
    assign keep = hs && (bus.wb_dst != '0);
    assign pop  = !bus.regs_hold && (count != '0);

`ifdef WB_FASTPATH_EN
    assign fast = keep && !bus.regs_hold && (count == '0);
`else
    assign fast = 1'b0;
`endif

    assign push = keep && !fast;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .din_i     (req),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count),
        .entries_o (entries),
        .vld_o     (ent_vld)
    );

    // Buffered entries always drain before a bypass; fast only fires when the FIFO is empty.
    always_comb begin
        port_d = port_q;
        sync_d = 1'b0;
        if (pop) begin
            port_d = head;
            sync_d = 1'b1;
        end else if (fast) begin
            port_d = req;
            sync_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_q <= '0;
            sync_q <= 1'b0;
        end else begin
            port_q <= port_d;
            sync_q <= sync_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = ent_vld[i] && (entries[i].dst == bus.rd_addr);
    end

    assign bus.wb_ready            = count < FULL;
    assign bus.wb_count            = count;
    assign bus.CtlToRegs_port      = port_q;
    assign bus.CtlToRegs_port_sync = sync_q;
    assign bus.rd_pending          = (bus.rd_addr != '0) &&
                                     ((|hit) || (sync_q && (port_q.dst == bus.rd_addr)));

endmodule

// File: tb/tb_regs_writeback_ctl.sv
// Bench for regs_writeback_ctl: queue-based reference model plus scenario tasks.
module tb_regs_writeback_ctl;
    import regs_writeback_ctl_pkg::*;

    localparam int DEPTH = 4;
`ifdef WB_FASTPATH_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    localparam int EXP_LAT = FP ? 1 : 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regs_writeback_ctl_if #(.DEPTH(DEPTH)) bus ();
    regs_writeback_ctl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: writes waiting in acceptance order, plus the last issued write.
    RegfileWriteType mq[$];
    bit              m_sync;
    RegfileWriteType m_port;

    function automatic bit m_pending(input logic [REG_AW-1:0] a);
        if (a == 0) return 1'b0;
        if (m_sync && m_port.dst == a) return 1'b1;
        foreach (mq[i]) if (mq[i].dst == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_sync = 1'b0;
        m_port = '0;
    endtask

    task automatic drive(input logic v, input logic [REG_AW-1:0] d, input unsigned_32 x);
        bus.wb_valid = v;
        bus.wb_dst   = d;
        bus.wb_data  = x;
    endtask

    // One rising edge; the model consumes the inputs that were present at that edge.
    task automatic tick();
        RegfileWriteType req;
        bit hs, fast;
        @(posedge clk);
        req.dst     = bus.wb_dst;
        req.dstdata = bus.wb_data;
        hs   = bus.wb_valid && (mq.size() < DEPTH);
        fast = FP && hs && (req.dst != 0) && (mq.size() == 0) && !bus.regs_hold;
        if (!bus.regs_hold && mq.size() > 0) begin
            m_port = mq.pop_front();
            m_sync = 1'b1;
        end else if (fast) begin
            m_port = req;
            m_sync = 1'b1;
        end else begin
            m_sync = 1'b0;
        end
        if (hs && req.dst != 0 && !fast) mq.push_back(req);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0);
        bus.regs_hold = 1'b0;
        bus.rd_addr   = '0;
        #1 rst = 1'b0;
        #2;
        model_clear();
        n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b0) begin n_err++; $display("FAIL reset_sync: got %0b want 0", bus.CtlToRegs_port_sync); end
        n_cmp++; if (bus.wb_count !== 0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.wb_count); end
        n_cmp++; if (bus.CtlToRegs_port !== '0) begin n_err++; $display("FAIL reset_port: got %0h want 0", bus.CtlToRegs_port); end
        n_cmp++; if (bus.wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", bus.wb_ready); end
        @(negedge clk) rst = 1'b1;
        tick();
        n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b0) begin n_err++; $display("FAIL reset_idle_sync: got %0b want 0", bus.CtlToRegs_port_sync); end
    endtask

    task automatic test_single();
        RegfileWriteType exp_w;
        int lat;
        exp_w.dst = 5; exp_w.dstdata = 32'hDEADBEEF;
        bus.regs_hold = 1'b0;
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        n_cmp++; if (bus.wb_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %0b want 1", bus.wb_ready); end
        tick();
        bus.wb_valid = 1'b0;
        lat = 1;
        while (bus.CtlToRegs_port_sync !== 1'b1 && lat < 6) begin tick(); lat++; end
        n_cmp++; if (lat != EXP_LAT) begin n_err++; $display("FAIL single_latency: got %0d want %0d", lat, EXP_LAT); end
        n_cmp++; if (bus.CtlToRegs_port !== exp_w) begin n_err++; $display("FAIL single_port: got %0h want %0h", bus.CtlToRegs_port, exp_w); end
        tick();
        n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b0) begin n_err++; $display("FAIL single_one_pulse: got %0b want 0", bus.CtlToRegs_port_sync); end
    endtask

    task automatic test_fill();
        unsigned_32 d[4];
        bus.regs_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            drive(1'b1, REG_AW'(i + 1), d[i]);
            tick();
        end
        bus.wb_valid = 1'b0;
        #1;
        n_cmp++; if (bus.wb_count !== 4) begin n_err++; $display("FAIL fill_count: got %0d want 4", bus.wb_count); end
        n_cmp++; if (bus.wb_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %0b want 0", bus.wb_ready); end
        for (int a = 1; a <= 6; a++) begin
            if (a == 5) continue;
            bus.rd_addr = REG_AW'(a);
            #1;
            n_cmp++; if (bus.rd_pending !== (a != 6)) begin n_err++; $display("FAIL fill_pending_%0d: got %0b want %0b", a, bus.rd_pending, a != 6); end
        end
        bus.regs_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b1) begin n_err++; $display("FAIL fill_sync_%0d: got %0b want 1", i, bus.CtlToRegs_port_sync); end
            n_cmp++; if (bus.CtlToRegs_port.dst !== REG_AW'(i + 1) || bus.CtlToRegs_port.dstdata !== d[i]) begin
                n_err++; $display("FAIL fill_order_%0d: got %0h want %0h_%0h", i, bus.CtlToRegs_port, i + 1, d[i]);
            end
            if (i == 0) begin
                n_cmp++; if (bus.wb_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_rise: got %0b want 1", bus.wb_ready); end
            end
        end
        tick();
        n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b0) begin n_err++; $display("FAIL fill_drained: got %0b want 0", bus.CtlToRegs_port_sync); end
    endtask

    task automatic test_x0();
        bus.regs_hold = 1'b0;
        bus.rd_addr   = '0;
        drive(1'b1, '0, 32'hFFFFFFFF);
        #1;
        n_cmp++; if (bus.wb_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %0b want 1", bus.wb_ready); end
        tick();
        bus.wb_valid = 1'b0;
        n_cmp++; if (bus.rd_pending !== 1'b0) begin n_err++; $display("FAIL x0_pending: got %0b want 0", bus.rd_pending); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b0) begin n_err++; $display("FAIL x0_sync_%0d: got %0b want 0", i, bus.CtlToRegs_port_sync); end
            n_cmp++; if (bus.wb_count !== 0) begin n_err++; $display("FAIL x0_count_%0d: got %0d want 0", i, bus.wb_count); end
            tick();
        end
    endtask

    task automatic test_same_dst();
        unsigned_32 got[$];
        int s2 = -1;
        int p0 = -1;
        bus.regs_hold = 1'b0;
        bus.rd_addr   = 5'd7;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 0)      drive(1'b1, 5'd7, 32'd1);
            else if (cyc == 1) drive(1'b1, 5'd7, 32'd2);
            else               bus.wb_valid = 1'b0;
            tick();
            if (bus.CtlToRegs_port_sync === 1'b1) begin
                got.push_back(bus.CtlToRegs_port.dstdata);
                if (got.size() == 2) s2 = cyc;
            end
            if (bus.rd_pending === 1'b0 && p0 < 0) p0 = cyc;
            n_cmp++; if (bus.rd_pending !== m_pending(5'd7)) begin n_err++; $display("FAIL same_pending_c%0d: got %0b want %0b", cyc, bus.rd_pending, m_pending(5'd7)); end
        end
        n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL same_strobes: got %0d want 2", got.size()); end
        else begin
            n_cmp++; if (got[0] !== 32'd1 || got[1] !== 32'd2) begin n_err++; $display("FAIL same_order: got %0h,%0h want 1,2", got[0], got[1]); end
        end
        n_cmp++; if (s2 < 0 || p0 != s2 + 1) begin n_err++; $display("FAIL same_pending_drop: got cycle %0d want %0d", p0, s2 + 1); end
    endtask

    task automatic test_wrap();
        RegfileWriteType acc[$], iss[$], req;
        int cyc = 0;
        while (acc.size() < 20 && cyc < 400) begin
            bus.regs_hold = cyc[1];
            drive(($urandom_range(3) != 0), REG_AW'($urandom_range(31)), $urandom);
            bus.rd_addr = REG_AW'($urandom_range(31));
            #1;
            n_cmp++; if (bus.wb_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL wrap_ready_c%0d: got %0b want %0b", cyc, bus.wb_ready, mq.size() < DEPTH); end
            n_cmp++; if (bus.rd_pending !== m_pending(bus.rd_addr)) begin n_err++; $display("FAIL wrap_pending_c%0d: got %0b want %0b", cyc, bus.rd_pending, m_pending(bus.rd_addr)); end
            req.dst = bus.wb_dst; req.dstdata = bus.wb_data;
            if (bus.wb_valid && mq.size() < DEPTH && req.dst != 0) acc.push_back(req);
            tick();
            if (bus.CtlToRegs_port_sync === 1'b1) iss.push_back(bus.CtlToRegs_port);
            n_cmp++; if (bus.CtlToRegs_port_sync !== m_sync) begin n_err++; $display("FAIL wrap_sync_c%0d: got %0b want %0b", cyc, bus.CtlToRegs_port_sync, m_sync); end
            n_cmp++; if (bus.wb_count !== mq.size()) begin n_err++; $display("FAIL wrap_count_c%0d: got %0d want %0d", cyc, bus.wb_count, mq.size()); end
            cyc++;
        end
        drive(1'b0, '0, '0);
        bus.regs_hold = 1'b0;
        repeat (DEPTH + 2) begin
            tick();
            if (bus.CtlToRegs_port_sync === 1'b1) iss.push_back(bus.CtlToRegs_port);
        end
        n_cmp++; if (acc.size() != 20) begin n_err++; $display("FAIL wrap_accepted: got %0d want 20 (cycle budget)", acc.size()); end
        n_cmp++; if (iss.size() != acc.size()) begin n_err++; $display("FAIL wrap_issued: got %0d want %0d", iss.size(), acc.size()); end
        for (int i = 0; i < acc.size() && i < iss.size(); i++) begin
            n_cmp++; if (iss[i] !== acc[i]) begin n_err++; $display("FAIL wrap_order_%0d: got %0h want %0h", i, iss[i], acc[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        bus.regs_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, REG_AW'(10 + i), $urandom);
            tick();
        end
        bus.wb_valid = 1'b0;
        n_cmp++; if (bus.wb_count !== 3) begin n_err++; $display("FAIL mid_count_pre: got %0d want 3", bus.wb_count); end
        bus.regs_hold = 1'b0;
        tick();
        n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b1) begin n_err++; $display("FAIL mid_sync_pre: got %0b want 1", bus.CtlToRegs_port_sync); end
        #2 rst = 1'b0;
        #1;
        model_clear();
        n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b0) begin n_err++; $display("FAIL mid_sync: got %0b want 0", bus.CtlToRegs_port_sync); end
        n_cmp++; if (bus.wb_count !== 0) begin n_err++; $display("FAIL mid_count: got %0d want 0", bus.wb_count); end
        n_cmp++; if (bus.CtlToRegs_port !== '0) begin n_err++; $display("FAIL mid_port: got %0h want 0", bus.CtlToRegs_port); end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.CtlToRegs_port_sync !== 1'b0) begin n_err++; $display("FAIL mid_no_strobe_%0d: got %0b want 0", i, bus.CtlToRegs_port_sync); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_x0();
        test_same_dst();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
